// File: rtl/prod_cons_fifo_top.sv
// prod_cons_fifo_top: rate-divided incrementing producer -> DEPTH-entry sync FIFO -> rate-divided
// consumer with sequence-continuity self-check. Traffic source/sink for bench and bring-up.
// Optional build macro STALL_CNT_EN: when defined, stall_cnt counts failed push attempts
// (saturating); when undefined, stall_cnt is tied to 0.
module prod_cons_fifo_top #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PROD_DIV  = 1,
    parameter int unsigned CONS_DIV  = 3,
    parameter int unsigned SEQ_START = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       prod_en,
    input  logic                       cons_en,
    output logic [WIDTH-1:0]           out,
    output logic                       out_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       prod_blocked,
    output logic                       seq_err,
    output logic [15:0]                stall_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {StProduce, StBlocked} state_e;

    state_e           state_q, state_d;
    logic [7:0]       pdiv_q, pdiv_d, cdiv_q, cdiv_d;
    logic [WIDTH-1:0] prod_val_q, prod_val_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             seq_err_q, seq_err_d;
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             p_tick, c_tick, push, push_fail, pop;
    logic [WIDTH-1:0] head;

    // Flags come from the registered count, so there is no same-cycle bypass either way.
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign push      = p_tick & ~full;
    assign push_fail = p_tick & full;
    assign pop       = c_tick & ~empty;
    assign head      = mem_q[rptr_q];

    // Rate dividers: hold while disabled, tick on the last count then wrap.
    always_comb begin
        pdiv_d = pdiv_q;
        p_tick = 1'b0;
        if (prod_en) begin
            if (pdiv_q == 8'(PROD_DIV - 1)) begin
                pdiv_d = '0;
                p_tick = 1'b1;
            end else begin
                pdiv_d = pdiv_q + 8'd1;
            end
        end
        cdiv_d = cdiv_q;
        c_tick = 1'b0;
        if (cons_en) begin
            if (cdiv_q == 8'(CONS_DIV - 1)) begin
                cdiv_d = '0;
                c_tick = 1'b1;
            end else begin
                cdiv_d = cdiv_q + 8'd1;
            end
        end
    end

    // Next state for producer FSM, pointers, occupancy and consumer/checker.
    always_comb begin
        state_d     = state_q;
        prod_val_d  = prod_val_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        out_d       = out_q;
        out_valid_d = pop;
        exp_d       = exp_q;
        seq_err_d   = seq_err_q;
        if (push) begin
            state_d    = StProduce;
            prod_val_d = prod_val_q + WIDTH'(1);
            wptr_d     = wptr_q + AW'(1);
        end else if (push_fail) begin
            // Value is held, so the retry writes the same value: nothing is dropped.
            state_d = StBlocked;
        end
        if (pop) begin
            out_d  = head;
            rptr_d = rptr_q + AW'(1);
            exp_d  = head + WIDTH'(1);
            if (head != exp_q) seq_err_d = 1'b1;
        end
    end

    // State registers; async reset discards FIFO contents and restarts the sequence.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StProduce;
            pdiv_q      <= '0;
            cdiv_q      <= '0;
            prod_val_q  <= WIDTH'(SEQ_START);
            exp_q       <= WIDTH'(SEQ_START);
            out_q       <= '0;
            out_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pdiv_q      <= pdiv_d;
            cdiv_q      <= cdiv_d;
            prod_val_q  <= prod_val_d;
            exp_q       <= exp_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            seq_err_q   <= seq_err_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage, written at the write pointer on a successful push.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wptr_q] <= prod_val_q;
        end
    end

`ifdef STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of failed push attempts.
    always_comb begin
        stall_d = stall_q;
        if (push_fail && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end

    // Stall counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

    assign out          = out_q;
    assign out_valid    = out_valid_q;
    assign count        = count_q;
    assign prod_blocked = (state_q == StBlocked);
    assign seq_err      = seq_err_q;
endmodule

// File: tb/tb_prod_cons_fifo_top.sv
// Directed, table-driven bench for prod_cons_fifo_top: default instance plus a
// PROD_DIV=1/CONS_DIV=1 instance. Honours STALL_CNT_EN for the stall_cnt expectation.
module tb_prod_cons_fifo_top;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pe_a = 1'b0, ce_a = 1'b0, pe_b = 1'b0, ce_b = 1'b0;
    logic [3:0]  out_a, out_b;
    logic        ov_a, ov_b, full_a, full_b, empty_a, empty_b;
    logic        blk_a, blk_b, serr_a, serr_b;
    logic [3:0]  cnt_a, cnt_b;
    logic [15:0] stall_a, stall_b;

    int tests = 0;
    int failed = 0;

    always #5 clock = ~clock;

    prod_cons_fifo_top dut (
        .clock(clock), .reset(reset), .prod_en(pe_a), .cons_en(ce_a),
        .out(out_a), .out_valid(ov_a), .count(cnt_a), .full(full_a), .empty(empty_a),
        .prod_blocked(blk_a), .seq_err(serr_a), .stall_cnt(stall_a)
    );

    prod_cons_fifo_top #(.PROD_DIV(1), .CONS_DIV(1)) dut_fast (
        .clock(clock), .reset(reset), .prod_en(pe_b), .cons_en(ce_b),
        .out(out_b), .out_valid(ov_b), .count(cnt_b), .full(full_b), .empty(empty_b),
        .prod_blocked(blk_b), .seq_err(serr_b), .stall_cnt(stall_b)
    );

    typedef struct {
        logic [3:0] cnt;
        logic       full;
        logic       empty;
        logic       blocked;
    } fill_vec_t;

    typedef struct {
        logic [3:0] cnt;
        logic       valid;
        logic [3:0] out;
    } fast_vec_t;

    fill_vec_t fill_tbl [10];
    fast_vec_t fast_tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
    endtask

    initial begin
        int first_pop, last_pop, pulses, cyc;
        logic [3:0] exp_out;
        logic       hit;

        // count/full/empty/blocked after each of 10 producer-only edges
        fill_tbl = '{
            '{4'd1, 1'b0, 1'b0, 1'b0}, '{4'd2, 1'b0, 1'b0, 1'b0},
            '{4'd3, 1'b0, 1'b0, 1'b0}, '{4'd4, 1'b0, 1'b0, 1'b0},
            '{4'd5, 1'b0, 1'b0, 1'b0}, '{4'd6, 1'b0, 1'b0, 1'b0},
            '{4'd7, 1'b0, 1'b0, 1'b0}, '{4'd8, 1'b1, 1'b0, 1'b0},
            '{4'd8, 1'b1, 1'b0, 1'b1}, '{4'd8, 1'b1, 1'b0, 1'b1}
        };
        // DIV=1 instance: push-only first edge, then push+pop every edge
        fast_tbl = '{
            '{4'd1, 1'b0, 4'd0}, '{4'd1, 1'b1, 4'd0}, '{4'd1, 1'b1, 4'd1},
            '{4'd1, 1'b1, 4'd2}, '{4'd1, 1'b1, 4'd3}
        };

        // 1: reset state
        do_reset();
        step();
        chk("rst_out", 32'(out_a), 0);
        chk("rst_count", 32'(cnt_a), 0);
        chk("rst_empty", 32'(empty_a), 1);
        chk("rst_full", 32'(full_a), 0);
        chk("rst_out_valid", 32'(ov_a), 0);
        chk("rst_blocked", 32'(blk_a), 0);
        chk("rst_seq_err", 32'(serr_a), 0);
        chk("rst_stall", 32'(stall_a), 0);

        // 2: fill with producer only
        pe_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("fill_count[%0d]", i + 1), 32'(cnt_a), 32'(fill_tbl[i].cnt));
            chk($sformatf("fill_full[%0d]", i + 1), 32'(full_a), 32'(fill_tbl[i].full));
            chk($sformatf("fill_empty[%0d]", i + 1), 32'(empty_a), 32'(fill_tbl[i].empty));
            chk($sformatf("fill_blocked[%0d]", i + 1), 32'(blk_a), 32'(fill_tbl[i].blocked));
        end
`ifdef STALL_CNT_EN
        chk("fill_stall", 32'(stall_a), 2);
`else
        chk("fill_stall", 32'(stall_a), 0);
`endif

        // 3: steady state with consumer enabled
        ce_a = 1'b1;
        exp_out = 4'd0;
        first_pop = 0;
        last_pop = 0;
        pulses = 0;
        for (int c = 1; c <= 1000; c++) begin
            step();
            if (ov_a) begin
                chk("steady_out", 32'(out_a), 32'(exp_out));
                exp_out = exp_out + 4'd1;
                if (pulses > 0) chk("steady_gap", 32'(c - last_pop), 3);
                else first_pop = c;
                last_pop = c;
                pulses++;
            end
            if (first_pop != 0 && c == first_pop + 1) chk("unblock_after_pop", 32'(blk_a), 0);
        end
        chk("steady_first_pop", 32'(first_pop), 3);
        chk("steady_pulses", 32'(pulses), 333);
        chk("steady_seq_err", 32'(serr_a), 0);
        pe_a = 1'b0;
        ce_a = 1'b0;

        // 4: DIV=1 instance from empty
        pe_b = 1'b1;
        ce_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("fast_count[%0d]", i + 1), 32'(cnt_b), 32'(fast_tbl[i].cnt));
            chk($sformatf("fast_valid[%0d]", i + 1), 32'(ov_b), 32'(fast_tbl[i].valid));
            if (fast_tbl[i].valid) chk($sformatf("fast_out[%0d]", i + 1), 32'(out_b),
                                       32'(fast_tbl[i].out));
        end
        exp_out = 4'd4;
        for (int i = 0; i < 30; i++) begin
            step();
            chk("fast_run_out", 32'(out_b), 32'(exp_out));
            chk("fast_run_count", 32'(cnt_b), 1);
            exp_out = exp_out + 4'd1;
        end
        chk("fast_seq_err", 32'(serr_b), 0);
        pe_b = 1'b0;
        ce_b = 1'b0;

        // 5: async reset mid-run at count=5
        do_reset();
        step();
        pe_a = 1'b1;
        ce_a = 1'b1;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < 50) begin
            step();
            cyc++;
            if (cnt_a == 4'd5) hit = 1'b1;
        end
        chk("mid_reach_count5", 32'(hit), 1);
        chk("mid_out_before", 32'(out_a), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_out", 32'(out_a), 0);
        chk("mid_rst_count", 32'(cnt_a), 0);
        chk("mid_rst_empty", 32'(empty_a), 1);
        chk("mid_rst_seq_err", 32'(serr_a), 0);
        chk("mid_rst_valid", 32'(ov_a), 0);
        #3;
        reset = 1'b1;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < 20) begin
            step();
            cyc++;
            if (ov_a) hit = 1'b1;
        end
        chk("post_rst_pop_seen", 32'(hit), 1);
        chk("post_rst_first_out", 32'(out_a), 0);
        chk("post_rst_first_cycle", 32'(cyc), 3);
        pe_a = 1'b0;
        ce_a = 1'b0;

        // 6: stall counter over 20 producer-only edges
        do_reset();
        step();
        pe_a = 1'b1;
        repeat (20) step();
`ifdef STALL_CNT_EN
        chk("stall_cnt_20", 32'(stall_a), 12);
`else
        chk("stall_cnt_20", 32'(stall_a), 0);
`endif
        chk("stall_blocked", 32'(blk_a), 1);
        chk("stall_full", 32'(full_a), 1);
        pe_a = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/prod_cons_fifo_top.md
Name: prod_cons_fifo_top

Overview:
- Parametrised producer/consumer subsystem, generalising the fixed 4-bit producer/consumer top.
- A rate-divided producer generates an incrementing WIDTH-bit sequence into a DEPTH-entry synchronous FIFO.
- A rate-divided consumer pops entries, drives them on `out` and self-checks sequence continuity.
- Sits at top level as the traffic source/sink for bench and board bring-up.

Parameters:
- WIDTH, 4: data width of the sequence and of `out`.
- DEPTH, 8: FIFO entries. Must be a power of 2 and ≥2.
- PROD_DIV, 1: producer makes one push attempt every PROD_DIV enabled cycles. Range 1..255.
- CONS_DIV, 3: consumer makes one pop attempt every CONS_DIV enabled cycles. Range 1..255.
- SEQ_START, 0: first value produced after reset.

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset. 0 = reset asserted.
- prod_en, input, 1: producer enable. Its divider holds while low.
- cons_en, input, 1: consumer enable. Its divider holds while low.
- out, output, WIDTH: last popped value, registered.
- out_valid, output, 1: one-cycle pulse on the cycle `out` updates.
- count, output, $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
- full, output, 1: count==DEPTH.
- empty, output, 1: count==0.
- prod_blocked, output, 1: producer FSM is in BLOCKED.
- seq_err, output, 1: sticky sequence mismatch flag.
- stall_cnt, output, 16: failed push attempts. See Optional Feature.

Behaviour:
- Reset (reset=0, async): all outputs and internal registers clear immediately.
  - out=0, out_valid=0, count=0, empty=1, full=0, seq_err=0, stall_cnt=0.
  - Producer value prod_val=SEQ_START; expected value exp=SEQ_START; FIFO pointers=0; dividers=0; FSM=PRODUCE.
  - Reset mid-operation discards all FIFO contents. After release the sequence restarts at SEQ_START.
- Dividers:
  - pdiv counts 0..PROD_DIV-1 while prod_en=1. Tick when pdiv==PROD_DIV-1, then wrap to 0.
  - cdiv behaves identically using cons_en and CONS_DIV.
  - With a DIV of 1, there is an attempt every enabled cycle.
- Producer FSM, two states:
  - PRODUCE: on tick with full=0, write prod_val and set prod_val <= prod_val+1 (mod 2^WIDTH). On tick with full=1, the push fails and the FSM goes to BLOCKED.
  - BLOCKED: prod_val is held. On each tick the push is retried. A successful push returns the FSM to PRODUCE. A failed retry stays in BLOCKED.
  - No value is ever dropped or skipped.
- Consumer:
  - On tick with empty=0: out <= FIFO head, out_valid=1 for one cycle, read pointer advances.
  - On tick with empty=1: out holds, out_valid=0.
- Full/empty gating:
  - full and empty are derived from the registered count.
  - A push while full is blocked even if a pop happens in the same cycle.
  - A pop while empty is blocked even if a push happens in the same cycle. There is no bypass path.
- Latency: a value written at edge N is poppable at edge N+1 at the earliest. It appears on `out` right after the popping edge.
- Simultaneous push and pop: both take effect and count is unchanged.
- Pointers: $clog2(DEPTH) bits, natural wrap. Data wrap 2^WIDTH-1 → 0 is legal.
- Sequence check:
  - On each pop, if head != exp then seq_err <= 1 (sticky until reset).
  - Then exp <= head+1 (mod 2^WIDTH).
  - In correct operation seq_err never asserts.

Optional Feature:
- Macro: STALL_CNT_EN.
- Defined: stall_cnt increments on every failed push attempt (tick while full) and saturates at 16'hFFFF.
- Not defined: no counter logic is built and stall_cnt is tied to 0.
- The port exists in both builds.

Test Plan:
All scenarios use default parameters unless stated.
1. Reset held low 3 cycles, then released with prod_en=cons_en=0 → out=0, count=0, empty=1, full=0, out_valid=0, prod_blocked=0.
2. prod_en=1, cons_en=0 for 10 edges → count=1..8 over edges 1–8, full=1 after edge 8, prod_blocked=1 after edge 9, FIFO holds 0..7.
3. Continue from 2 with cons_en=1 for 1000 cycles →
   - out_valid pulses every 3rd cycle.
   - out sequence is 0,1,2,…,15,0,1,… with no gaps.
   - prod_blocked drops after the first pop.
   - seq_err stays 0.
4. CONS_DIV=1, PROD_DIV=1, both enables raised from empty →
   - Edge 1: push only, count=1.
   - From edge 2: simultaneous push+pop, count stays 1.
   - out increments by 1 every cycle.
5. Async reset asserted mid-run with count=5, between clock edges →
   - out=0, count=0, empty=1, seq_err=0 immediately.
   - After release, first popped value is 0.
6. STALL_CNT_EN defined, prod_en=1, cons_en=0 for 20 edges → stall_cnt=12 (failures at edges 9–20). With the macro undefined, stall_cnt=0.
